// File: rtl/udp_tx_sched_if.sv
// Client, stack and status signals around the shared TX buffer scheduler.
// master drives the clients and the stack; slave is the scheduler itself.
interface udp_tx_sched_if #(
    parameter int unsigned AWIDTH = 6
);
    logic [1:0]        cli_req;
    logic [1:0]        cli_grant;
    logic [1:0]        cli_rel;
    logic [1:0]        cli_done;
    logic [63:0]       cli_rdata;
    logic [AWIDTH-1:0] cli_addr;
    logic              txbuf_grant;
    logic              txbuf_rel;
    logic [AWIDTH-1:0] txbuf_addr;
    logic [31:0]       txbuf_rdata;
    logic              owner;
    logic              busy;
    logic              timeout_err;

    modport master (
        output cli_req, cli_rel, cli_rdata, txbuf_grant, txbuf_addr,
        input  cli_grant, cli_done, cli_addr, txbuf_rel, txbuf_rdata, owner, busy, timeout_err
    );

    modport slave (
        input  cli_req, cli_rel, cli_rdata, txbuf_grant, txbuf_addr,
        output cli_grant, cli_done, cli_addr, txbuf_rel, txbuf_rdata, owner, busy, timeout_err
    );
endinterface

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one UDP TX buffer between two clients.
// All status outputs are registered; only the data and address paths are combinational.
module udp_tx_sched #(
    parameter int unsigned AWIDTH  = 6,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic           clk,
    input logic           rst,
    udp_tx_sched_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StGrant, StRel, StSend} state_e;

    localparam bit          TimeoutEn = (TIMEOUT != 0);
    localparam logic [15:0] HoldMax   = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic        owner_q;
    logic        last_owner_q;
    logic        seen_low_q;
    logic [15:0] hold_cnt_q;
    logic [1:0]  cli_grant_q;
    logic [1:0]  cli_done_q;
    logic        txbuf_rel_q;
    logic        timeout_err_q;
    logic        busy_q;

    logic pick;
    logic own_rel;
    logic own_req;
    logic hold_expired;

    always_comb begin
        pick = 1'b0;
        case (bus.cli_req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_owner_q;
            default: pick = 1'b0;
        endcase
    end

    assign own_rel      = bus.cli_rel[owner_q];
    assign own_req      = bus.cli_req[owner_q];
    assign hold_expired = TimeoutEn && (hold_cnt_q == HoldMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            seen_low_q    <= 1'b0;
            hold_cnt_q    <= 16'd0;
            cli_grant_q   <= 2'b00;
            cli_done_q    <= 2'b00;
            txbuf_rel_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cli_done_q    <= 2'b00;
            txbuf_rel_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.txbuf_grant && (bus.cli_req != 2'b00)) begin
                        state_q     <= StGrant;
                        owner_q     <= pick;
                        hold_cnt_q  <= 16'd0;
                        cli_grant_q <= pick ? 2'b10 : 2'b01;
                        busy_q      <= 1'b1;
                    end
                end
                StGrant: begin
                    hold_cnt_q <= hold_cnt_q + 16'd1;
                    // Losing the buffer outranks everything; a release outranks the timeout.
                    if (!bus.txbuf_grant || (!own_rel && !own_req)) begin
                        state_q     <= StIdle;
                        cli_grant_q <= 2'b00;
                        busy_q      <= 1'b0;
                    end else if (own_rel) begin
                        state_q     <= StRel;
                        cli_grant_q <= 2'b00;
                        txbuf_rel_q <= 1'b1;
                    end else if (hold_expired) begin
                        state_q       <= StIdle;
                        cli_grant_q   <= 2'b00;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        last_owner_q  <= owner_q;
                    end
                end
                StRel: begin
                    state_q    <= StSend;
                    seen_low_q <= 1'b0;
                end
                StSend: begin
                    if (!bus.txbuf_grant) begin
                        seen_low_q <= 1'b1;
                    end else if (seen_low_q) begin
                        state_q      <= StIdle;
                        cli_done_q   <= owner_q ? 2'b10 : 2'b01;
                        last_owner_q <= owner_q;
                        busy_q       <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cli_grant   = cli_grant_q;
    assign bus.cli_done    = cli_done_q;
    assign bus.txbuf_rel   = txbuf_rel_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = busy_q;
    assign bus.owner       = owner_q;
    assign bus.cli_addr    = bus.txbuf_addr;
    assign bus.txbuf_rdata = owner_q ? bus.cli_rdata[63:32] : bus.cli_rdata[31:0];
endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: stimulus queues expected events, a negedge monitor checks them.
module tb_udp_tx_sched;
    localparam logic [1:0] EvGrant = 2'd0;
    localparam logic [1:0] EvRel   = 2'd1;
    localparam logic [1:0] EvDone  = 2'd2;
    localparam logic [1:0] EvTmo   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    ev_t  sb[$];
    logic [1:0] prev_grant = 2'b00;

    udp_tx_sched_if #(.AWIDTH(6)) ifc ();

    udp_tx_sched #(.AWIDTH(6), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(logic [1:0] kind, logic [1:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endfunction

    function automatic void observe(logic [1:0] kind, logic [1:0] val);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d val %0d, expected none", kind, val);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 64'(kind), 64'(e.kind));
            chk("sb_val", 64'(val), 64'(e.val));
        end
    endfunction

    // Monitor: every grant rise and output pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (ifc.cli_grant == 2'b11) begin
            checks++;
            failures++;
            $display("FAIL grant_onehot: got 11 expected one-hot or zero");
        end
        if (ifc.cli_grant != 2'b00 && prev_grant == 2'b00) observe(EvGrant, ifc.cli_grant);
        if (ifc.txbuf_rel) observe(EvRel, {1'b0, ifc.owner});
        if (ifc.cli_done != 2'b00) observe(EvDone, ifc.cli_done);
        if (ifc.timeout_err) observe(EvTmo, {1'b0, ifc.owner});
        prev_grant <= ifc.cli_grant;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant();
        int n = 0;
        while (ifc.cli_grant == 2'b00 && n < 10) begin
            cyc(1);
            n++;
        end
        chk("grant_seen", 64'(ifc.cli_grant != 2'b00), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ifc.busy && n < 10) begin
            cyc(1);
            n++;
        end
        chk("idle_seen", 64'(ifc.busy), 64'd0);
    endtask

    // Called right after the rel sample (FSM in REL): stack takes the buffer and returns it.
    task automatic finish_send();
        ifc.cli_req     = 2'b00;
        ifc.txbuf_grant = 1'b0;
        cyc(2);
        ifc.txbuf_grant = 1'b1;
        wait_idle();
    endtask

    task automatic xact(input logic [1:0] req, input bit exp_o, input bit last);
        logic [1:0] oh;
        oh = exp_o ? 2'b10 : 2'b01;
        push(EvGrant, oh);
        push(EvRel, {1'b0, exp_o});
        push(EvDone, oh);
        ifc.cli_req     = req;
        ifc.txbuf_grant = 1'b1;
        wait_grant();
        chk("xact_owner", 64'(ifc.owner), 64'(exp_o));
        ifc.cli_rel = ifc.cli_grant;
        cyc(1);
        ifc.cli_rel     = 2'b00;
        ifc.txbuf_grant = 1'b0;
        cyc(3);
        ifc.txbuf_grant = 1'b1;
        wait_idle();
        if (last) ifc.cli_req = 2'b00;
    endtask

    initial begin
        int n;
        logic [31:0] lo;
        ifc.cli_req     = 2'b00;
        ifc.cli_rel     = 2'b00;
        ifc.cli_rdata   = 64'hBBBB_0002_AAAA_0001;
        ifc.txbuf_grant = 1'b0;
        ifc.txbuf_addr  = 6'd5;
        cyc(2);
        rst = 1'b0;
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_grant", 64'(ifc.cli_grant), 64'd0);
        chk("rst_owner", 64'(ifc.owner), 64'd0);
        chk("rst_txbuf_rel", 64'(ifc.txbuf_rel), 64'd0);
        chk("rst_done", 64'(ifc.cli_done), 64'd0);
        chk("rst_tmo", 64'(ifc.timeout_err), 64'd0);
        chk("rst_rdata_sel", 64'(ifc.txbuf_rdata), 64'hAAAA_0001);
        chk("rst_addr_fwd", 64'(ifc.cli_addr), 64'd5);

        // Single requester, full transaction with data readout.
        push(EvGrant, 2'b01);
        push(EvRel, 2'b00);
        push(EvDone, 2'b01);
        ifc.txbuf_grant = 1'b1;
        ifc.cli_req     = 2'b01;
        cyc(1);
        chk("grant_latency", 64'(ifc.cli_grant), 64'h1);
        cyc(4);
        ifc.cli_rel = 2'b01;
        cyc(1);
        ifc.cli_rel = 2'b00;
        ifc.cli_req = 2'b00;
        chk("rel_pulse", 64'(ifc.txbuf_rel), 64'd1);
        chk("rel_grant_off", 64'(ifc.cli_grant), 64'd0);
        ifc.txbuf_grant = 1'b0;
        cyc(1);
        for (int a = 0; a < 7; a++) begin
            lo = 32'hA000_0000 + 32'(a);
            ifc.txbuf_addr = 6'(a);
            ifc.cli_rdata  = {32'hB000_0000 + 32'(a), lo};
            #1;
            chk("send_rdata", 64'(ifc.txbuf_rdata), 64'(lo));
            chk("send_addr", 64'(ifc.cli_addr), 64'(a));
            cyc(1);
        end
        cyc(12);
        ifc.txbuf_grant = 1'b1;
        cyc(1);
        chk("done_pulse", 64'(ifc.cli_done), 64'h1);
        chk("done_busy", 64'(ifc.busy), 64'd0);

        // Contention after reset: 0, 1, 0.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        xact(2'b11, 1'b0, 1'b0);
        xact(2'b11, 1'b1, 1'b0);
        xact(2'b11, 1'b0, 1'b1);

        // Timeout with client 1 holding the grant.
        push(EvGrant, 2'b10);
        push(EvTmo, 2'b01);
        ifc.cli_req = 2'b10;
        wait_grant();
        n = 0;
        while (ifc.cli_grant != 2'b00 && n < 40) begin
            n++;
            cyc(1);
        end
        ifc.cli_req = 2'b00;
        chk("tmo_hold_cycles", 64'(n), 64'd16);
        chk("tmo_pulse", 64'(ifc.timeout_err), 64'd1);
        chk("tmo_busy", 64'(ifc.busy), 64'd0);
        cyc(2);

        // Rel on the same cycle the timeout would fire.
        push(EvGrant, 2'b01);
        push(EvRel, 2'b00);
        push(EvDone, 2'b01);
        ifc.cli_req = 2'b01;
        wait_grant();
        cyc(15);
        ifc.cli_rel = 2'b01;
        cyc(1);
        ifc.cli_rel = 2'b00;
        chk("coll_rel", 64'(ifc.txbuf_rel), 64'd1);
        chk("coll_no_tmo", 64'(ifc.timeout_err), 64'd0);
        finish_send();

        // Non-owner rel is ignored.
        push(EvGrant, 2'b01);
        push(EvRel, 2'b00);
        push(EvDone, 2'b01);
        ifc.cli_req = 2'b01;
        wait_grant();
        ifc.cli_rel = 2'b10;
        cyc(1);
        ifc.cli_rel = 2'b00;
        chk("nonowner_grant", 64'(ifc.cli_grant), 64'h1);
        chk("nonowner_busy", 64'(ifc.busy), 64'd1);
        cyc(2);
        ifc.cli_rel = 2'b01;
        cyc(1);
        ifc.cli_rel = 2'b00;
        finish_send();

        // Reset in SEND, with the stack returning the buffer on the same edge.
        push(EvGrant, 2'b10);
        push(EvRel, 2'b01);
        ifc.cli_req = 2'b10;
        wait_grant();
        ifc.cli_rel = 2'b10;
        cyc(1);
        ifc.cli_rel     = 2'b00;
        ifc.cli_req     = 2'b00;
        ifc.txbuf_grant = 1'b0;
        ifc.cli_rdata   = 64'h1234_5678_9ABC_DEF0;
        cyc(2);
        chk("send_busy", 64'(ifc.busy), 64'd1);
        chk("send_rdata_hi", 64'(ifc.txbuf_rdata), 64'h1234_5678);
        ifc.txbuf_grant = 1'b1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_send_busy", 64'(ifc.busy), 64'd0);
        chk("rst_send_grant", 64'(ifc.cli_grant), 64'd0);
        chk("rst_send_done", 64'(ifc.cli_done), 64'd0);
        xact(2'b11, 1'b0, 1'b1);

        // Requester drops its request while granted.
        push(EvGrant, 2'b10);
        ifc.cli_req = 2'b10;
        wait_grant();
        ifc.cli_req = 2'b00;
        cyc(1);
        chk("reqdrop_busy", 64'(ifc.busy), 64'd0);
        chk("reqdrop_grant", 64'(ifc.cli_grant), 64'd0);

        // Stack takes the buffer back during GRANT.
        push(EvGrant, 2'b01);
        ifc.cli_req = 2'b01;
        wait_grant();
        cyc(2);
        ifc.txbuf_grant = 1'b0;
        cyc(1);
        ifc.cli_req = 2'b00;
        chk("gloss_busy", 64'(ifc.busy), 64'd0);
        chk("gloss_grant", 64'(ifc.cli_grant), 64'd0);
        cyc(3);
        ifc.txbuf_grant = 1'b1;
        cyc(3);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/udp_tx_sched.md
UDP_TX_SCHED -- requirements
Module: udp_tx_sched

Interface
REQ-001 SHALL have parameter AWIDTH, default 6: width of the TX buffer word address.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum cycles a client may hold a grant without releasing; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cli_req, input, 2: per-client request for the TX buffer.
REQ-006 SHALL have port cli_grant, output, 2: per-client grant, one-hot or zero.
REQ-007 SHALL have port cli_rel, input, 2: per-client one-cycle pulse meaning "buffer filled, send it".
REQ-008 SHALL have port cli_done, output, 2: per-client one-cycle pulse when the stack has finished reading that client's packet.
REQ-009 SHALL have port cli_rdata, input, 64: client read data; bits [31:0] are client 0 and bits [63:32] are client 1.
REQ-010 SHALL have port cli_addr, output, AWIDTH: txbuf_addr forwarded to both clients.
REQ-011 SHALL have port txbuf_grant, input, 1: from the stack, high while the buffer is owned by the user side.
REQ-012 SHALL have port txbuf_rel, output, 1: to the stack, one-cycle pulse that hands the filled buffer over.
REQ-013 SHALL have port txbuf_addr, input, AWIDTH: read address from the stack.
REQ-014 SHALL have port txbuf_rdata, output, 32: the owner's word.
REQ-015 SHALL have port owner, output, 1: index of the current or last client.
REQ-016 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have port timeout_err, output, 1: one-cycle pulse when a grant is revoked.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, GRANT, REL, SEND.
REQ-019 IDLE -> GRANT SHALL occur when txbuf_grant=1 and cli_req!=0; the owner is registered on that edge, and cli_grant[owner]=1 from the next cycle.
REQ-020 Arbitration SHALL be round-robin: the client other than last_owner wins when both request; a single requester always wins.
REQ-021 In GRANT, cli_rel[owner]=1 SHALL move the FSM to REL; cli_rel from the non-owner SHALL be ignored.
REQ-022 In GRANT, dropping cli_req[owner] SHALL return the FSM to IDLE next cycle without asserting txbuf_rel.
REQ-023 In REL, txbuf_rel SHALL be 1 for exactly one cycle and cli_grant SHALL be 0; the FSM then moves to SEND.
REQ-024 In SEND, txbuf_rdata SHALL equal the owner's cli_rdata slice combinationally, and cli_addr SHALL equal txbuf_addr combinationally in every state.
REQ-025 SEND -> IDLE SHALL occur on the first cycle that txbuf_grant is 1 after it was seen 0 in SEND; that cycle SHALL pulse cli_done[owner] and set last_owner=owner.
REQ-026 A 16-bit hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-027 When TIMEOUT!=0 and the hold counter reaches TIMEOUT-1 without cli_rel, the FSM SHALL return to IDLE, pulse timeout_err, set last_owner=owner, and not assert txbuf_rel.
REQ-028 If cli_rel[owner] and the timeout occur in the same cycle, the rel SHALL win.
REQ-029 If txbuf_grant drops while in GRANT, the FSM SHALL return to IDLE, drop the grant, and not pulse cli_done.
REQ-030 Outside SEND, txbuf_rdata SHALL still select owner; cli_grant SHALL be 0 in IDLE, REL and SEND.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL enter IDLE and set cli_grant=0, cli_done=0, txbuf_rel=0, timeout_err=0, busy=0, owner=0, last_owner=1 and the hold counter to 0.
REQ-032 rst SHALL override every other input in any state, including mid-SEND; no txbuf_rel or cli_done pulse is emitted on the reset cycle.
REQ-033 After reset, the first contention SHALL be won by client 0.

Verification
REQ-034 Single requester: txbuf_grant=1, cli_req=01, rel after 5 cycles, txbuf_grant low 20 cycles then high -> cli_grant=01 one cycle after req; txbuf_rel one pulse; txbuf_rdata=cli_rdata[31:0] at addr 0..6; cli_done=01 once.
REQ-035 Contention: cli_req=11 held, three full transactions -> owners are 0, 1, 0 in that order; cli_grant is never 11.
REQ-036 Timeout: TIMEOUT=16, client 1 granted, no rel -> timeout_err on the 16th GRANT cycle; txbuf_rel stays 0; the FSM returns to IDLE.
REQ-037 Edge collisions: rel and timeout in the same cycle -> txbuf_rel pulses and no timeout_err; cli_rel=10 while owner=0 -> ignored, FSM stays in GRANT.
REQ-038 Reset mid-SEND: rst=1 during SEND -> next cycle busy=0, cli_grant=00, no cli_done; the next contention is won by client 0.
REQ-039 Grant loss: txbuf_grant drops during GRANT -> IDLE, cli_grant=00, no txbuf_rel.
